// File: rtl/sprite_row_scanner_mc.sv
// Per-line sprite frontend: scans the attribute table for sprites crossing the next line,
// queues hits in index order and hands each one to the lowest-numbered idle drawer channel.
module sprite_row_scanner_mc #(
  parameter int unsigned NUM_SPRITE = 32,
  parameter int unsigned MAX_SLOT   = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SPRITE_H   = 16,
  parameter int unsigned ROW_LIMIT  = 0,
  parameter int unsigned VIS_LINES  = 480
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start_row,
  input  logic [9:0]                         next_vcount,
  output logic [$clog2(NUM_SPRITE)-1:0]      ra,
  input  logic [31:0]                        rd_data,
  output logic [NUM_CH-1:0]                  draw_req,
  input  logic [NUM_CH-1:0]                  draw_ack,
  output logic [NUM_CH*10-1:0]               col_base,
  output logic [NUM_CH-1:0]                  flip,
  output logic [NUM_CH*8-1:0]                frame_id,
  output logic [NUM_CH*$clog2(SPRITE_H)-1:0] row_off,
  output logic [5:0]                         hit_count,
  output logic                               row_overflow,
  output logic                               fe_done
);

  localparam int unsigned AW = $clog2(NUM_SPRITE);
  localparam int unsigned SW = $clog2(MAX_SLOT);
  localparam int unsigned OW = SW + 1;
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned EW = 19 + RW;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           ra_q, ra_d;
  logic                    eval_v_q, eval_v_d, eval_last_q, eval_last_d;
  logic                    all_issued_q, all_issued_d;
  logic [9:0]              vcount_q, vcount_d;
  logic [SW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [NUM_CH-1:0]       busy_q, busy_d, draw_req_q, draw_req_d, flip_q, flip_d;
  logic [NUM_CH*10-1:0]    col_base_q, col_base_d;
  logic [NUM_CH*8-1:0]     frame_q, frame_d;
  logic [NUM_CH*RW-1:0]    row_off_q, row_off_d;
  logic [5:0]              hit_count_q, hit_count_d;
  logic                    overflow_q, overflow_d, fe_done_q, fe_done_d;
  logic [EW-1:0]           mem_q [MAX_SLOT];
  logic [10:0]             vc11_c, y11_c;
  logic                    hit_c, push_c, pop_c, issue_c, found_c;
  logic [EW-1:0]           push_data_c, head_data_c;
  logic                    unused_rsvd_c;

  assign unused_rsvd_c = ^rd_data[29:27];

  always_comb begin
    state_d      = state_q;
    ra_d         = ra_q;
    eval_v_d     = 1'b0;
    eval_last_d  = 1'b0;
    all_issued_d = all_issued_q;
    vcount_d     = vcount_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    busy_d       = busy_q;
    draw_req_d   = '0;
    col_base_d   = col_base_q;
    flip_d       = flip_q;
    frame_d      = frame_q;
    row_off_d    = row_off_q;
    hit_count_d  = hit_count_q;
    overflow_d   = overflow_q;
    fe_done_d    = fe_done_q;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    found_c      = 1'b0;

    // 11-bit compare so y + SPRITE_H never wraps into low lines
    vc11_c      = {1'b0, vcount_q};
    y11_c       = {2'b00, rd_data[26:18]};
    hit_c       = eval_v_q && rd_data[31] && (vc11_c >= y11_c) && (vc11_c < y11_c + 11'(SPRITE_H));
    push_data_c = {rd_data[17:8], rd_data[30], rd_data[7:0], RW'(vc11_c - y11_c)};
    head_data_c = mem_q[head_q];

    // Issue a read only when the FIFO can absorb both the in-flight and the new evaluation
    issue_c = (state_q == SCAN) && !all_issued_q &&
              (32'(occ_q) + 32'(eval_v_q) <= MAX_SLOT - 1);
    if (issue_c) begin
      eval_v_d    = 1'b1;
      eval_last_d = (ra_q == AW'(NUM_SPRITE - 1));
      if (ra_q == AW'(NUM_SPRITE - 1)) all_issued_d = 1'b1;
      else                             ra_d = ra_q + AW'(1);
    end

    if (hit_c) begin
      if (ROW_LIMIT == 0 || 32'(hit_count_q) < ROW_LIMIT) begin
        push_c = 1'b1;
        if (hit_count_q != 6'd63) hit_count_d = hit_count_q + 6'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (draw_ack[i] && busy_q[i]) busy_d[i] = 1'b0;
    end

    if (state_q != IDLE && occ_q != '0) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (!found_c && !busy_q[i]) begin
          found_c                 = 1'b1;
          pop_c                   = 1'b1;
          busy_d[i]               = 1'b1;
          draw_req_d[i]           = 1'b1;
          col_base_d[i*10 +: 10]  = head_data_c[EW-1 -: 10];
          flip_d[i]               = head_data_c[EW-11];
          frame_d[i*8 +: 8]       = head_data_c[EW-12 -: 8];
          row_off_d[i*RW +: RW]   = head_data_c[RW-1:0];
        end
      end
    end

    case (state_q)
      SCAN:    if (eval_v_q && eval_last_q) state_d = DRAIN;
      DRAIN:   if (occ_q == '0 && busy_q == '0) begin
                 state_d   = IDLE;
                 fe_done_d = 1'b1;
               end
      default: ;
    endcase

    if (push_c) tail_d = tail_q + SW'(1);
    if (pop_c)  head_d = head_q + SW'(1);
    occ_d = occ_q + OW'(push_c) - OW'(pop_c);

    // A new row abandons whatever the previous one left behind
    if (start_row) begin
      push_c       = 1'b0;
      ra_d         = '0;
      eval_v_d     = 1'b0;
      eval_last_d  = 1'b0;
      all_issued_d = 1'b0;
      vcount_d     = next_vcount;
      head_d       = '0;
      tail_d       = '0;
      occ_d        = '0;
      busy_d       = '0;
      draw_req_d   = '0;
      hit_count_d  = '0;
      overflow_d   = 1'b0;
      if (32'(next_vcount) < VIS_LINES) begin
        state_d   = SCAN;
        fe_done_d = 1'b0;
      end else begin
        state_d   = IDLE;
        fe_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ra_q         <= '0;
      eval_v_q     <= 1'b0;
      eval_last_q  <= 1'b0;
      all_issued_q <= 1'b0;
      vcount_q     <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      occ_q        <= '0;
      busy_q       <= '0;
      draw_req_q   <= '0;
      col_base_q   <= '0;
      flip_q       <= '0;
      frame_q      <= '0;
      row_off_q    <= '0;
      hit_count_q  <= '0;
      overflow_q   <= 1'b0;
      fe_done_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      ra_q         <= ra_d;
      eval_v_q     <= eval_v_d;
      eval_last_q  <= eval_last_d;
      all_issued_q <= all_issued_d;
      vcount_q     <= vcount_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      busy_q       <= busy_d;
      draw_req_q   <= draw_req_d;
      col_base_q   <= col_base_d;
      flip_q       <= flip_d;
      frame_q      <= frame_d;
      row_off_q    <= row_off_d;
      hit_count_q  <= hit_count_d;
      overflow_q   <= overflow_d;
      fe_done_q    <= fe_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem_q[tail_q] <= push_data_c;
  end

  assign ra           = ra_q;
  assign draw_req     = draw_req_q;
  assign col_base     = col_base_q;
  assign flip         = flip_q;
  assign frame_id     = frame_q;
  assign row_off      = row_off_q;
  assign hit_count    = hit_count_q;
  assign row_overflow = overflow_q;
  assign fe_done      = fe_done_q;

endmodule

// File: tb/tb_sprite_row_scanner_mc.sv
// Scoreboard bench for sprite_row_scanner_mc: one instance with a 4-deep FIFO and no
// row limit, one with a row limit of 10; drawers are modelled with a fixed ack delay.
module tb_sprite_row_scanner_mc;

  localparam int NCH = 2;

  typedef struct packed {
    logic [9:0] col;
    logic       flip;
    logic [7:0] frame;
    logic [3:0] roff;
  } pay_t;

  typedef struct packed {
    int   exp_ch;
    int   got_ch;
    pay_t pay;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  start_row_v;
  logic [9:0]  next_vcount;
  logic [4:0]  ra_a, ra_b, ra_m;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  req_a, req_b, req_m, ack_a, ack_b, ack_v;
  logic [1:0]  flip_a, flip_b, flip_m;
  logic [19:0] col_a, col_b, col_m;
  logic [15:0] frm_a, frm_b, frm_m;
  logic [7:0]  roff_a, roff_b, roff_m;
  logic [5:0]  hc_a, hc_b, hc_m;
  logic        ovf_a, ovf_b, ovf_m, fe_a, fe_b, fe_m;
  logic [31:0] attr [32];
  int          sel;
  int          n_pass;
  int          n_checks;
  pay_t        exp_q [$];
  obs_t        obs_q [$];

  always #5 clk = ~clk;

  sprite_row_scanner_mc #(.MAX_SLOT(4), .ROW_LIMIT(0)) u_a (
    .clk(clk), .reset_n(reset_n), .start_row(start_row_v[0]), .next_vcount(next_vcount),
    .ra(ra_a), .rd_data(rd_a), .draw_req(req_a), .draw_ack(ack_a), .col_base(col_a),
    .flip(flip_a), .frame_id(frm_a), .row_off(roff_a), .hit_count(hc_a),
    .row_overflow(ovf_a), .fe_done(fe_a));

  sprite_row_scanner_mc #(.MAX_SLOT(8), .ROW_LIMIT(10)) u_b (
    .clk(clk), .reset_n(reset_n), .start_row(start_row_v[1]), .next_vcount(next_vcount),
    .ra(ra_b), .rd_data(rd_b), .draw_req(req_b), .draw_ack(ack_b), .col_base(col_b),
    .flip(flip_b), .frame_id(frm_b), .row_off(roff_b), .hit_count(hc_b),
    .row_overflow(ovf_b), .fe_done(fe_b));

  always @(posedge clk) begin
    rd_a <= attr[ra_a];
    rd_b <= attr[ra_b];
  end

  assign ack_a = (sel == 0) ? ack_v : 2'b00;
  assign ack_b = (sel == 1) ? ack_v : 2'b00;

  always_comb begin
    if (sel == 0) begin
      ra_m = ra_a; req_m = req_a; flip_m = flip_a; col_m = col_a; frm_m = frm_a;
      roff_m = roff_a; hc_m = hc_a; ovf_m = ovf_a; fe_m = fe_a;
    end else begin
      ra_m = ra_b; req_m = req_b; flip_m = flip_b; col_m = col_b; frm_m = frm_b;
      roff_m = roff_b; hc_m = hc_b; ovf_m = ovf_b; fe_m = fe_b;
    end
  end

  function automatic logic [31:0] mk(input logic en, input logic fl, input int y, input int x, input int fr);
    return {en, fl, 3'b000, 9'(y), 10'(x), 8'(fr)};
  endfunction

  function automatic void clear_attr();
    for (int k = 0; k < 32; k++) attr[k] = 32'h0;
  endfunction

  // Reference: scan entries in index order, keep the first 'limit' hits
  function automatic int push_expected(input int vc, input int limit);
    int   n;
    int   y;
    pay_t p;
    n = 0;
    for (int k = 0; k < 32; k++) begin
      y = int'(attr[k][26:18]);
      if (attr[k][31] && vc >= y && vc < y + 16 && (limit == 0 || n < limit)) begin
        p.col   = attr[k][17:8];
        p.flip  = attr[k][30];
        p.frame = attr[k][7:0];
        p.roff  = 4'(vc - y);
        exp_q.push_back(p);
        n++;
      end
    end
    return n;
  endfunction

  // Runs one row on the selected instance, acting as the drawers and logging each dispatch
  task automatic run_row(input int vc, input int dly, input int budget, output logic to, output logic stall);
    int         ack_at [NCH];
    logic [1:0] busy_m;
    logic [4:0] ra_prev;
    obs_t       o;
    busy_m = '0;
    to     = 1'b1;
    stall  = 1'b0;
    ack_v  = '0;
    for (int c = 0; c < NCH; c++) ack_at[c] = -1;
    @(negedge clk);
    next_vcount      = 10'(vc);
    start_row_v[sel] = 1'b1;
    @(negedge clk);
    start_row_v = '0;
    ra_prev     = ra_m;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (req_m != 2'b00) begin
        o.exp_ch = 99;
        for (int c = NCH - 1; c >= 0; c--) if (!busy_m[c]) o.exp_ch = c;
        o.got_ch = 99;
        if ($countones(req_m) == 1)
          for (int c = 0; c < NCH; c++) if (req_m[c]) o.got_ch = c;
        o.pay = '0;
        if (o.got_ch < NCH) begin
          o.pay.col   = col_m[o.got_ch*10 +: 10];
          o.pay.flip  = flip_m[o.got_ch];
          o.pay.frame = frm_m[o.got_ch*8 +: 8];
          o.pay.roff  = roff_m[o.got_ch*4 +: 4];
          busy_m[o.got_ch] = 1'b1;
          ack_at[o.got_ch] = cyc + dly;
        end
        obs_q.push_back(o);
      end
      busy_m = busy_m & ~ack_v;
      ack_v  = '0;
      for (int c = 0; c < NCH; c++) if (busy_m[c] && ack_at[c] == cyc) ack_v[c] = 1'b1;
      if (!fe_m && cyc > 0 && ra_m == ra_prev && ra_m != 5'd31) stall = 1'b1;
      ra_prev = ra_m;
      if (fe_m && busy_m == 2'b00 && ack_v == 2'b00) begin
        to = 1'b0;
        break;
      end
    end
    ack_v = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_row_v = '0; next_vcount = '0; ack_v = '0; sel = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ra_m, req_m, col_m, flip_m, frm_m, roff_m} !== '0) $display("FAIL reset_fields: got %h want 0", {ra_m, req_m, col_m, flip_m, frm_m, roff_m});
    else n_pass++;
    n_checks++;
    if (hc_m !== 6'd0 || ovf_m !== 1'b0) $display("FAIL reset_count: got hc=%0d ovf=%b want 0 0", hc_m, ovf_m);
    else n_pass++;
    n_checks++;
    if (fe_a !== 1'b1 || fe_b !== 1'b1) $display("FAIL reset_fe_done: got %b%b want 11", fe_a, fe_b);
    else n_pass++;
  endtask

  task automatic test_index_order();
    logic to, st;
    obs_t o;
    pay_t e;
    int   want_ch [3] = '{0, 1, 0};
    int   k;
    sel = 0; k = 0;
    clear_attr();
    attr[0]  = mk(1'b1, 1'b0, 100, 40,   8'h11);
    attr[5]  = mk(1'b1, 1'b1, 100, 300,  8'h22);
    attr[31] = mk(1'b1, 1'b0, 100, 1000, 8'h33);
    void'(push_expected(107, 0));
    run_row(107, 10, 500, to, st);
    n_checks++;
    if (to) $display("FAIL order_timeout: fe_done not seen within budget"); else n_pass++;
    n_checks++;
    if (obs_q.size() != 3) $display("FAIL order_count: got %0d want 3", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.pay !== e || o.got_ch !== want_ch[k] || o.pay.roff !== 4'd7)
        $display("FAIL order_dispatch%0d: got ch%0d %h want ch%0d %h", k, o.got_ch, o.pay, want_ch[k], e);
      else n_pass++;
      k = (k < 2) ? k + 1 : 2;
    end
    n_checks++;
    if (hc_m !== 6'd3 || fe_m !== 1'b1) $display("FAIL order_final: got hc=%0d fe=%b want 3 1", hc_m, fe_m);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_boundary();
    logic to, st;
    obs_t o;
    pay_t e;
    int   vcs   [5] = '{99, 116, 100, 115, 5};
    int   wantn [5] = '{0, 0, 1, 1, 0};
    sel = 0;
    clear_attr();
    attr[3] = mk(1'b1, 1'b1, 100, 77, 8'h5A);
    attr[7] = mk(1'b1, 1'b0, 500, 88, 8'hC3);
    for (int r = 0; r < 5; r++) begin
      void'(push_expected(vcs[r], 0));
      run_row(vcs[r], 2, 300, to, st);
      n_checks++;
      if (to || obs_q.size() != wantn[r])
        $display("FAIL bound_count vc=%0d: got %0d (timeout=%b) want %0d", vcs[r], obs_q.size(), to, wantn[r]);
      else n_pass++;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_checks++;
        if (o.pay !== e || o.got_ch !== o.exp_ch)
          $display("FAIL bound_dispatch vc=%0d: got ch%0d %h want ch%0d %h", vcs[r], o.got_ch, o.pay, o.exp_ch, e);
        else n_pass++;
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    logic to, st;
    obs_t o;
    pay_t e;
    int   n;
    sel = 0;
    for (int k = 0; k < 32; k++) attr[k] = mk(1'b1, k[0], 92 + (k % 16), k * 7 + 1, k ^ 8'hA5);
    void'(push_expected(107, 0));
    run_row(107, 20, 3000, to, st);
    n = 0;
    n_checks++;
    if (to || obs_q.size() != 32) $display("FAIL bp_count: got %0d (timeout=%b) want 32", obs_q.size(), to);
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.pay !== e || o.got_ch !== o.exp_ch)
        $display("FAIL bp_dispatch%0d: got ch%0d %h want ch%0d %h", n, o.got_ch, o.pay, o.exp_ch, e);
      else n_pass++;
      n++;
    end
    n_checks++;
    if (st !== 1'b1) $display("FAIL bp_stall: got stall_seen=%b want 1", st); else n_pass++;
    n_checks++;
    if (hc_m !== 6'd32 || ovf_m !== 1'b0) $display("FAIL bp_final: got hc=%0d ovf=%b want 32 0", hc_m, ovf_m);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_row_limit();
    logic to, st;
    obs_t o;
    pay_t e;
    sel = 1;
    clear_attr();
    for (int j = 0; j < 12; j++) attr[2*j + 2] = mk(1'b1, j[1], 200, j * 11 + 5, 8'h40 + j);
    void'(push_expected(210, 10));
    run_row(210, 3, 1000, to, st);
    n_checks++;
    if (to || obs_q.size() != 10) $display("FAIL limit_count: got %0d (timeout=%b) want 10", obs_q.size(), to);
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.pay !== e || o.got_ch !== o.exp_ch)
        $display("FAIL limit_dispatch: got ch%0d %h want ch%0d %h", o.got_ch, o.pay, o.exp_ch, e);
      else n_pass++;
    end
    n_checks++;
    if (hc_m !== 6'd10 || ovf_m !== 1'b1) $display("FAIL limit_final: got hc=%0d ovf=%b want 10 1", hc_m, ovf_m);
    else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_abort_and_reset();
    int   w;
    logic seen;
    sel = 0; ack_v = '0;
    clear_attr();
    for (int k = 0; k < 3; k++) attr[k] = mk(1'b1, 1'b1, 100, 50 + k, 8'h70 + k);
    @(negedge clk);
    next_vcount = 10'd107; start_row_v[0] = 1'b1;
    @(negedge clk);
    start_row_v = '0;
    w = 0;
    while (ra_m !== 5'd31 && w < 200) begin @(negedge clk); w++; end
    n_checks++;
    if (ra_m !== 5'd31) $display("FAIL abort_scan: got ra=%0d want 31", ra_m); else n_pass++;
    repeat (3) @(negedge clk);
    ack_v = 2'b01;
    @(negedge clk);
    ack_v = '0; next_vcount = 10'd481; start_row_v[0] = 1'b1;
    @(negedge clk);
    start_row_v = '0;
    n_checks++;
    if (req_m !== 2'b00 || fe_m !== 1'b1) $display("FAIL abort_req: got req=%b fe=%b want 00 1", req_m, fe_m);
    else n_pass++;
    n_checks++;
    if (hc_m !== 6'd0 || ra_m !== 5'd0 || ovf_m !== 1'b0) $display("FAIL abort_clear: got hc=%0d ra=%0d ovf=%b want 0 0 0", hc_m, ra_m, ovf_m);
    else n_pass++;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (req_m != 2'b00 || fe_m != 1'b1) seen = 1'b1; end
    n_checks++;
    if (seen) $display("FAIL abort_quiet: got activity=1 want 0"); else n_pass++;

    for (int k = 0; k < 32; k++) attr[k] = mk(1'b1, 1'b1, 100, k + 1, k + 1);
    @(negedge clk);
    next_vcount = 10'd107; start_row_v[0] = 1'b1;
    @(negedge clk);
    start_row_v = '0;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ra_m, req_m, col_m, flip_m, frm_m, roff_m} !== '0) $display("FAIL async_fields: got %h want 0", {ra_m, req_m, col_m, flip_m, frm_m, roff_m});
    else n_pass++;
    n_checks++;
    if (hc_m !== 6'd0 || ovf_m !== 1'b0 || fe_m !== 1'b1) $display("FAIL async_status: got hc=%0d ovf=%b fe=%b want 0 0 1", hc_m, ovf_m, fe_m);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_checks = 0; sel = 0; ack_v = '0;
    start_row_v = '0; next_vcount = '0; reset_n = 1'b0;
    clear_attr();
    test_reset();
    test_index_order();
    test_boundary();
    test_backpressure();
    test_row_limit();
    test_abort_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_row_scanner_mc.md
Name: sprite_row_scanner_mc

Overview:
Multi-channel successor to the single-drawer sprite frontend. On each start_row it scans the sprite attribute table for sprites that intersect next_vcount. Hits are queued in a circular FIFO in ascending sprite-index order, and each hit is dispatched to the lowest-numbered idle drawer channel. Sprite height, FIFO depth, drawer count and a per-row sprite limit are parameters. An overflow flag reports the row when its hit count exceeds the limit. The block sits between the attribute RAM and NUM_CH line-buffer drawers.

Parameters:
NUM_SPRITE, 32, attribute table entries (power of 2, >=2)
MAX_SLOT, 8, FIFO depth (power of 2, >=2)
NUM_CH, 2, drawer channels (1..4)
SPRITE_H, 16, sprite height in lines (power of 2, 2..64); RW = log2(SPRITE_H)
ROW_LIMIT, 0, max sprites accepted per row; 0 = unlimited
VIS_LINES, 480, visible line count

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start_row  in  1  one-cycle pulse: begin processing line next_vcount
next_vcount  in  10  line to prepare
ra  out  log2(NUM_SPRITE)  attribute RAM read address
rd_data  in  32  attribute word, valid 1 cycle after ra. Fields: [31] enable, [30] flip, [26:18] y, [17:8] x, [7:0] frame
draw_req  out  NUM_CH  per-channel one-cycle dispatch pulse
draw_ack  in  NUM_CH  per-channel one-cycle pulse from the drawer: job finished
col_base  out  NUM_CH*10  channel i at [10i+9:10i]
flip  out  NUM_CH  per-channel flip
frame_id  out  NUM_CH*8  per-channel frame
row_off  out  NUM_CH*RW  per-channel row offset
hit_count  out  6  hits accepted this row (saturating at 63)
row_overflow  out  1  a hit was discarded this row due to ROW_LIMIT
fe_done  out  1  1 = row complete or blanking

Behaviour:
- Reset values (async, reset_n=0): ra=0, all draw_req=0, col_base/flip/frame_id/row_off=0, hit_count=0, row_overflow=0, fe_done=1, FIFO empty, all channels idle, FSM=IDLE.
- FSM states: IDLE, SCAN, DRAIN.
- start_row is accepted in any state. It aborts current work: FIFO cleared, channel busy flags cleared, draw_req forced to 0, hit_count=0, row_overflow=0, ra=0.
  - next_vcount < VIS_LINES: next state SCAN, fe_done=0.
  - Otherwise: next state IDLE, fe_done=1.
- SCAN: ra increments once per cycle from 0 to NUM_SPRITE-1. Entry k's data is evaluated one cycle after ra=k.
- Hit test: enable && next_vcount >= y && next_vcount < y+SPRITE_H.
  - Compare in 11-bit unsigned; no wrap.
  - row_off = (next_vcount - y) truncated to RW bits.
- Hit accepted, and ROW_LIMIT=0 or hit_count<ROW_LIMIT: entry pushed at tail; hit_count increments.
- Hit beyond ROW_LIMIT: discarded; row_overflow=1 (sticky until start_row/reset).
- Backpressure: ra advances only if FIFO occupancy plus the in-flight evaluation is <= MAX_SLOT-1, so a pending hit always fits.
  - While stalled, ra holds and the held entry is evaluated exactly once (no duplicate push).
- SCAN -> DRAIN once entry NUM_SPRITE-1 has been evaluated.
- Dispatch: at most one per cycle, any state except IDLE.
  - Condition: FIFO non-empty and at least one idle channel.
  - Target: lowest-index idle channel i. Its output fields are loaded and draw_req[i]=1 for exactly one cycle; head advances.
  - Channel i goes busy on dispatch and returns to idle on the cycle draw_ack[i]=1. It can be re-dispatched the following cycle.
  - draw_ack on an idle channel is ignored.
- Push and pop in the same cycle are both performed. Occupancy is held as a separate counter so full (MAX_SLOT) and empty are distinguished.
- DRAIN -> IDLE with fe_done=1 on the first cycle where the FIFO is empty and all channels are idle.
- Output fields hold their last dispatched values between requests.

Test Plan:
1. Sprites 0, 5, 31 enabled at y=100; start_row with vcount=107 -> three draw_req pulses in index order on ch0, ch1, ch0 (ch0 re-dispatched after its ack); row_off=7 each; hit_count=3; then fe_done=1.
2. SPRITE_H=16, sprite y=100: vcount 99 and 116 -> no hit; vcount 100 -> row_off 0; vcount 115 -> row_off 15. Also y=500 with vcount=5 -> no hit (no wrap).
3. All 32 sprites hit, MAX_SLOT=4, drawers ack after 20 cycles -> ra stalls, no entry lost or duplicated, 32 dispatches in order, row_overflow=0.
4. ROW_LIMIT=10 with 12 hits -> 10 dispatches (sprites with the lowest indices), hit_count=10, row_overflow=1.
5. start_row mid-DRAIN with vcount=481 -> draw_req=0 next cycle, FIFO empty, fe_done=1. Then reset_n pulsed low mid-SCAN -> all outputs at reset values immediately (asynchronous).
